// File: rtl/ex_mem_pipe_reg.sv
// Elastic EX/MEM pipeline register with valid/ready on both sides, flush and a stall counter.
// Define SKID_BUF_EN to add a one-beat skid slot that decouples in_ready from out_ready.
module ex_mem_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int WB_W   = 2,
  parameter int M_W    = 2,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   in_ctlwb,
  input  logic [M_W-1:0]    in_ctlm,
  input  logic [XLEN-1:0]   in_adder,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_rdata2,
  input  logic [REG_AW-1:0] in_muxout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   out_ctlwb,
  output logic [M_W-1:0]    out_ctlm,
  output logic [XLEN-1:0]   out_adder,
  output logic [XLEN-1:0]   out_alu_result,
  output logic [XLEN-1:0]   out_rdata2,
  output logic [REG_AW-1:0] out_muxout,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [WB_W-1:0]   ctlwb;
    logic [M_W-1:0]    ctlm;
    logic [XLEN-1:0]   adder;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   rdata2;
    logic [REG_AW-1:0] muxout;
  } beat_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  beat_t            in_beat;
  beat_t            main_q;
  logic             out_valid_q;
  logic             in_fire;
  logic [CNT_W-1:0] stall_cnt_q;

  assign in_beat = '{ctlwb:      in_ctlwb,
                     ctlm:       in_ctlm,
                     adder:      in_adder,
                     alu_result: in_alu_result,
                     rdata2:     in_rdata2,
                     muxout:     in_muxout};

  assign in_fire = in_valid & in_ready;

`ifdef SKID_BUF_EN
  beat_t skid_q;
  logic  skid_valid_q;

  // in_ready only sees registered state and flush, so out_ready never reaches it.
  assign in_ready = rst_n & ~skid_valid_q & ~flush;

  // NOTE: payload registers are reset too, so every out_* reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Main slot frees up this edge: the skid beat is older, so it goes first.
      if (skid_valid_q) begin
        main_q       <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_fire) begin
        main_q      <= in_beat;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q       <= in_beat;
      skid_valid_q <= 1'b1;
    end
  end
`else
  assign in_ready = rst_n & ~flush & (~out_valid_q | out_ready);

  // NOTE: payload registers are reset too, so every out_* reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      main_q      <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (in_fire) begin
      main_q      <= in_beat;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_ready && !flush && stall_cnt_q != CNT_MAX) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // Control fields are gated on bubbles so MEM/WB never act on a stale beat.
  assign out_valid      = out_valid_q;
  assign out_ctlwb      = out_valid_q ? main_q.ctlwb : '0;
  assign out_ctlm       = out_valid_q ? main_q.ctlm  : '0;
  assign out_adder      = main_q.adder;
  assign out_alu_result = main_q.alu_result;
  assign out_rdata2     = main_q.rdata2;
  assign out_muxout     = main_q.muxout;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: scoreboard of accepted beats plus directed checks.
// Runs in either build; expectations that differ follow SKID_BUF_EN.
module tb_ex_mem_pipe_reg;

  localparam int XLEN   = 32;
  localparam int WB_W   = 2;
  localparam int M_W    = 2;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int PW     = WB_W + M_W + 3 * XLEN + REG_AW;

`ifdef SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WB_W-1:0]   in_ctlwb;
  logic [M_W-1:0]    in_ctlm;
  logic [XLEN-1:0]   in_adder;
  logic [XLEN-1:0]   in_alu_result;
  logic [XLEN-1:0]   in_rdata2;
  logic [REG_AW-1:0] in_muxout;
  logic              out_valid;
  logic              out_ready;
  logic [WB_W-1:0]   out_ctlwb;
  logic [M_W-1:0]    out_ctlm;
  logic [XLEN-1:0]   out_adder;
  logic [XLEN-1:0]   out_alu_result;
  logic [XLEN-1:0]   out_rdata2;
  logic [REG_AW-1:0] out_muxout;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  logic [PW-1:0] sb_q[$];

  ex_mem_pipe_reg #(
    .XLEN(XLEN), .WB_W(WB_W), .M_W(M_W), .REG_AW(REG_AW), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctlwb(in_ctlwb), .in_ctlm(in_ctlm), .in_adder(in_adder),
    .in_alu_result(in_alu_result), .in_rdata2(in_rdata2), .in_muxout(in_muxout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctlwb(out_ctlwb), .out_ctlm(out_ctlm), .out_adder(out_adder),
    .out_alu_result(out_alu_result), .out_rdata2(out_rdata2), .out_muxout(out_muxout),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Payload fields derived from the alu value so each beat is distinguishable.
  task automatic set_beat(input logic [XLEN-1:0] alu);
    in_alu_result = alu;
    in_adder      = alu ^ 32'h5A5A_0000;
    in_rdata2     = ~alu;
    in_muxout     = alu[REG_AW-1:0];
    in_ctlwb      = alu[1:0] ^ 2'b11;
    in_ctlm       = alu[2:1] | 2'b01;
  endtask

  // Advance one cycle and withdraw the offered beat once it has been taken.
  task automatic step_offer();
    logic taken;
    taken = in_valid & in_ready;
    step();
    if (taken) in_valid = 1'b0;
  endtask

  // Scoreboard: push on in_fire, pop and compare on out_fire, empty on flush/reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("sb_extra_beat", 128'd1, 128'd0);
        else check("sb_beat",
                   {out_ctlwb, out_ctlm, out_adder, out_alu_result, out_rdata2, out_muxout},
                   sb_q.pop_front());
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready)
        sb_q.push_back({in_ctlwb, in_ctlm, in_adder, in_alu_result, in_rdata2, in_muxout});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_beat('0);
    step(); step();
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1 check("rel_in_ready", in_ready, 1);

    // Reset asserted while a beat is held.
    set_beat(32'h55); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctlwb", out_ctlwb, 0);
    check("rst_out_adder", out_adder, 0);
    check("rst_out_alu", out_alu_result, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_in_ready2", in_ready, 0);
    step(); step();
    rst_n = 1'b1;
    #1 check("rel_in_ready2", in_ready, 1);

    // Single beat.
    out_ready = 1'b1;
    in_ctlwb = 2'b01; in_ctlm = 2'b10; in_adder = 32'h1234_5678;
    in_alu_result = 32'hABCD_EF01; in_rdata2 = 32'h0F0F_0F0F; in_muxout = 5'h1A;
    in_valid = 1'b1;
    step(); in_valid = 1'b0;
    check("single_valid", out_valid, 1);
    check("single_ctlwb", out_ctlwb, 2'b01);
    check("single_ctlm", out_ctlm, 2'b10);
    check("single_adder", out_adder, 32'h1234_5678);
    check("single_alu", out_alu_result, 32'hABCD_EF01);
    check("single_rdata2", out_rdata2, 32'h0F0F_0F0F);
    check("single_muxout", out_muxout, 5'h1A);
    step();
    check("bubble_valid", out_valid, 0);
    check("bubble_ctlwb", out_ctlwb, 0);
    check("bubble_ctlm", out_ctlm, 0);
    check("bubble_adder", out_adder, 32'h1234_5678);

    // Streaming at full throughput.
    for (int i = 0; i < 8; i++) begin
      set_beat(i); in_valid = 1'b1;
      step();
      check("stream_valid", out_valid, 1);
      check("stream_alu", out_alu_result, i);
    end
    in_valid = 1'b0;
    step();
    check("stream_end_valid", out_valid, 0);
    check("stream_stall_cnt", stall_cnt, 0);

    // Back-pressure: hold A, offer B.
    out_ready = 1'b0;
    set_beat(32'hA); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    set_beat(32'hB); in_valid = 1'b1;
    #1 check("bp_in_ready_first", in_ready, SKID);
    for (int i = 0; i < 3; i++) step_offer();
    check("bp_stall_cnt", stall_cnt, 3);
    check("bp_hold_alu", out_alu_result, 32'hA);
    check("bp_hold_valid", out_valid, 1);
    check("bp_in_ready_full", in_ready, 0);
    out_ready = 1'b1;
    #1 step_offer();
    check("bp_drain_valid", out_valid, 1);
    check("bp_drain_alu", out_alu_result, 32'hB);
    in_valid = 1'b0;
    step();
    check("bp_drain_end", out_valid, 0);

    // Flush with A held (and B in skid when present).
    out_ready = 1'b0;
    set_beat(32'hA); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    set_beat(32'hB); in_valid = 1'b1;
    step_offer();
    in_valid = 1'b0;
    flush = 1'b1;
    #1 check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    #1;
    check("flush_valid", out_valid, 0);
    check("flush_ctlwb", out_ctlwb, 0);
    check("flush_ctlm", out_ctlm, 0);
    check("flush_in_ready_after", in_ready, 1);
    check("flush_stall_cnt", stall_cnt, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_beat", out_valid, 0);
    end

    // Stall counter saturation.
    out_ready = 1'b0;
    set_beat(32'h77); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("sat_mid", stall_cnt, 4'hE);
    for (int i = 0; i < 10; i++) step();
    check("sat_full", stall_cnt, 4'hF);
    step(); step();
    check("sat_hold", stall_cnt, 4'hF);
    out_ready = 1'b1;
    step(); step();
    check("final_idle", out_valid, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
